decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction-decode stage sitting directly upstream of the ALU in the 16-bit processor.
- Accepts 16-bit instructions from fetch over a valid/ready handshake and reads operands from an internal register file.
- Tracks in-flight writes with a scoreboard and presents a registered opcode/a/b/destination bundle to the ALU.
- Owns the register file write port, which is driven by writeback.

Parameters:
- DATA_W, 16, operand/register width.
- NUM_REGS, 16, register count; R0 hardwired to zero.
- REG_AW, 4, register address width (log2 NUM_REGS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  16  instruction: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt; [7:0] imm8 for LI.
- in_valid  in  1  instr valid.
- in_ready  out  1  decode accepts instr this cycle.
- alu_opcode  out  4  ALU opcode (0010 add, 0011 sub).
- alu_a  out  DATA_W  operand a.
- alu_b  out  DATA_W  operand b.
- dest  out  REG_AW  destination register of the issued op.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts bundle.
- illegal  out  1  one-cycle pulse, undefined opcode consumed.
- wb_en  in  1  writeback strobe.
- wb_addr  in  REG_AW  writeback register.
- wb_data  in  DATA_W  writeback value.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, illegal=0, alu_opcode/alu_a/alu_b/dest=0.
  - All registers =0; scoreboard cleared.
  - wb_en during reset is ignored.
  - Reset mid-handshake drops the pending bundle.
- Opcodes:
  - 0000 NOP: consumed, no output, no scoreboard change.
  - 0001 LI: issues opcode 0010, a=0, b=sign-extend(imm8), dest=rd.
  - 0010 ADD: issues opcode 0010, a=R[rs], b=R[rt], dest=rd.
  - 0011 SUB: issues opcode 0011, a=R[rs], b=R[rt], dest=rd.
  - Others: consumed, illegal=1 for exactly the next cycle, no output.
- Handshake:
  - Output register is a single stage; in_ready = (!out_valid || out_ready) && !hazard.
  - Accept = in_valid && in_ready.
  - Output fields load on accept of LI/ADD/SUB and stay stable while out_valid && !out_ready.
  - out_valid clears on out_ready when there is no new issue.
  - Back-to-back issue: one per cycle when out_ready is held high.
- Scoreboard (NUM_REGS bits):
  - On issue with rd!=0, set pend[rd].
  - On wb_en, clear pend[wb_addr].
  - Set and clear of the same register in the same cycle: set wins.
- Hazard:
  - ADD/SUB: pend[rs] or pend[rt] set (R0 never pending).
  - LI: no sources.
  - Stalled instruction is held by upstream; decode latches nothing.
- Register file:
  - Write on wb_en, wb_addr!=0.
  - Writes to R0 are ignored; R0 always reads 0.
- Latency: accept at edge N, bundle valid after edge N (one cycle).
- Arithmetic: pure pass-through/sign extension; no width growth.

Optional Feature:
- DECODE_BYPASS_EN
  - Defined: a source whose pending bit is cleared by wb in the same cycle is not a hazard. The operand takes wb_data (wb-to-decode forwarding). A simultaneous register-file read of wb_addr also returns wb_data.
  - Undefined: no forwarding; the hazard persists until the cycle after wb_en, costing one stall cycle per dependency. The register file reads the old value during the write cycle.

Decomposition:
- Package proc_pkg: DATA_W, REG_AW, opcode localparams (OP_NOP, OP_LI, OP_ADD, OP_SUB), instruction field bit positions.
- Sub-module regfile: 2 async read ports, 1 sync write port, R0 zero, async active-low reset.
- decode_stage contains field decode, scoreboard, hazard/handshake, output register.

Test Plan:
- Reset sequence: rst_n=0 with in_valid=1 and wb_en=1 -> out_valid=0, illegal=0, in_ready=1 after release; ADD r1,r0,r0 -> a=0, b=0.
- LI r1,0x05 then LI r2,0xFF, out_ready=1 -> bundles {0010,0,0x0005,1} then {0010,0,0xFFFF,2} on consecutive cycles.
- LI r1,5 issued, then ADD r3,r1,r1 with no wb -> in_ready=0. Then wb_en r1=0x0005:
  - with bypass: accepted that cycle, a=b=0x0005.
  - without bypass: accepted the next cycle.
- out_ready=0 for 3 cycles after SUB r4,r1,r2 issue -> outputs constant, in_ready=0; out_ready=1 -> next instr accepted same cycle.
- instr=0xF123 -> illegal=1 for one cycle, out_valid unchanged, scoreboard unchanged; NOP 0x0000 -> nothing.
- wb_en r0=0xBEEF, then ADD r5,r0,r0 -> a=b=0; LI r0,7 issues but does not set pend[0].

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants for the 16-bit processor pipeline.
// Build option DECODE_BYPASS_EN enables wb-to-decode forwarding.
package proc_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LI  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_AW-1:0] dest;
    } id_ex_t;

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
        return {{(DATA_W-8){v[7]}}, v};
    endfunction

endpackage

// File: rtl/regfile.sv
// Register file: two async read ports, one sync write port, R0 is zero.
// With DECODE_BYPASS_EN a read of the register being written returns wb data.
module regfile
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Write port; R0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    // Read port 1
    always_comb begin
        rd1 = (ra1 == '0) ? '0 : mem[ra1];
`ifdef DECODE_BYPASS_EN
        if (we && wa != '0 && wa == ra1) rd1 = wd;
`endif
    end

    // Read port 2
    always_comb begin
        rd2 = (ra2 == '0) ? '0 : mem[ra2];
`ifdef DECODE_BYPASS_EN
        if (we && wa != '0 && wa == ra2) rd2 = wd;
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, scoreboard, hazard stall, ALU output register.
// Build option DECODE_BYPASS_EN lets a same-cycle writeback resolve a hazard.
module decode_stage
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [REG_AW-1:0] dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              illegal,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [3:0]          op;
    logic [REG_AW-1:0]   rd, rs, rt;
    logic [7:0]          imm;
    logic                is_li, is_add, is_sub, is_bad;
    logic                accept, issue, hazard;
    logic [DATA_W-1:0]   rdata1, rdata2;
    logic [NUM_REGS-1:0] pend, pend_src, pend_nxt;
    logic [NUM_REGS-1:0] wb_clr, set_mask;
    id_ex_t              nxt, out_q;

    localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    assign op  = instr[OP_HI:OP_LO];
    assign rd  = instr[RD_HI:RD_LO];
    assign rs  = instr[RS_HI:RS_LO];
    assign rt  = instr[RT_HI:RT_LO];
    assign imm = instr[IMM_HI:IMM_LO];

    regfile u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rdata1),
        .rd2   (rdata2),
        .we    (wb_en),
        .wa    (wb_addr),
        .wd    (wb_data)
    );

    // Opcode class decode; NOP is consumed without side effects
    always_comb begin
        is_li  = 1'b0;
        is_add = 1'b0;
        is_sub = 1'b0;
        is_bad = 1'b0;
        unique case (1'b1)
            (op == OP_NOP): ;
            (op == OP_LI):  is_li  = 1'b1;
            (op == OP_ADD): is_add = 1'b1;
            (op == OP_SUB): is_sub = 1'b1;
            default:        is_bad = 1'b1;
        endcase
    end

    assign wb_clr = wb_en ? (ONE << wb_addr) : '0;

`ifdef DECODE_BYPASS_EN
    assign pend_src = pend & ~wb_clr;
`else
    assign pend_src = pend;
`endif

    // Source hazard for register-reading ops; R0 never blocks
    always_comb begin
        hazard = 1'b0;
        if (in_valid && (is_add || is_sub)) begin
            hazard = ((rs != '0) && pend_src[rs]) ||
                     ((rt != '0) && pend_src[rt]);
        end
    end

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && (is_li || is_add || is_sub);

    // Next ALU bundle and scoreboard update (set beats clear)
    always_comb begin
        nxt.opcode = is_sub ? ALU_SUB : ALU_ADD;
        nxt.a      = is_li ? '0 : rdata1;
        nxt.b      = is_li ? sext8(imm) : rdata2;
        nxt.dest   = rd;
        set_mask   = (issue && rd != '0) ? (ONE << rd) : '0;
        pend_nxt   = ((pend & ~wb_clr) | set_mask) & ~ONE;
    end

    // Output register, illegal pulse and scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            pend      <= '0;
        end else begin
            pend    <= pend_nxt;
            illegal <= accept && is_bad;
            if (issue) begin
                out_q     <= nxt;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign alu_opcode = out_q.opcode;
    assign alu_a      = out_q.a;
    assign alu_b      = out_q.b;
    assign dest       = out_q.dest;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage with an expected-bundle queue.
// Timing expectations follow DECODE_BYPASS_EN.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  dest;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        illegal;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;

    int tests = 0;
    int fails = 0;
    logic [39:0] exp_q [$];
    logic [15:0] model [16];

    decode_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .dest       (dest),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .illegal    (illegal),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] mk(input logic [3:0] o,
        input logic [15:0] a, input logic [15:0] b,
        input logic [3:0] d);
        return {o, a, b, d};
    endfunction

    // Pop and compare every bundle transferred to the ALU
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [39:0] e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL bundle_unexpected got=%h",
                    {alu_opcode, alu_a, alu_b, dest});
            end else begin
                e = exp_q.pop_front();
                if ({alu_opcode, alu_a, alu_b, dest} !== e) begin
                    fails++;
                    $display("FAIL bundle got=%h exp=%h",
                        {alu_opcode, alu_a, alu_b, dest}, e);
                end
            end
        end
    end

    task automatic send(input logic [15:0] ins, output int stalls);
        stalls = 0;
        instr = ins;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout instr=%h", ins);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [3:0] a, input logic [15:0] d);
        wb_en = 1'b1;
        wb_addr = a;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        if (a != 4'd0) model[a] = d;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        int s;
        for (int i = 0; i < 16; i++) model[i] = '0;
        rst_n = 1'b0;
        in_valid = 1'b1;
        instr = 16'h2100;
        wb_en = 1'b1;
        wb_addr = 4'd1;
        wb_data = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL rst_out_valid got=%b exp=0", out_valid);
        end
        tests++;
        if (illegal !== 1'b0) begin
            fails++; $display("FAIL rst_illegal got=%b exp=0", illegal);
        end
        tests++;
        if ({alu_opcode, alu_a, alu_b, dest} !== 40'h0) begin
            fails++;
            $display("FAIL rst_bundle got=%h exp=0",
                {alu_opcode, alu_a, alu_b, dest});
        end
        in_valid = 1'b0;
        wb_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL rst_in_ready got=%b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(mk(4'b0010, 16'h0, 16'h0, 4'd6));
        send(16'h2611, s);
        exp_q.push_back(mk(4'b0010, 16'h0, 16'h0, 4'd1));
        send(16'h2100, s);
        drain();
        wb(4'd6, 16'h0);
        wb(4'd1, 16'h0);
    endtask

    task automatic test_li_back_to_back();
        int s1, s2;
        out_ready = 1'b1;
        exp_q.push_back(mk(4'b0010, 16'h0, 16'h0005, 4'd1));
        send(16'h1105, s1);
        exp_q.push_back(mk(4'b0010, 16'h0, 16'hFFFF, 4'd2));
        send(16'h12FF, s2);
        tests++;
        if (s1 != 0 || s2 != 0) begin
            fails++; $display("FAIL b2b_stalls got=%0d,%0d exp=0,0", s1, s2);
        end
        @(negedge clk);
        tests++;
        if ({out_valid, alu_b, dest} !== {1'b1, 16'hFFFF, 4'd2}) begin
            fails++;
            $display("FAIL b2b_second got=%b/%h/%h exp=1/ffff/2",
                out_valid, alu_b, dest);
        end
        @(posedge clk);
        #1;
        drain();
        wb(4'd1, 16'h0005);
        wb(4'd2, 16'hFFFF);
    endtask

    task automatic test_hazard();
        int s;
        exp_q.push_back(mk(4'b0010, 16'h0, 16'h0005, 4'd1));
        send(16'h1105, s);
        instr = 16'h2311;
        in_valid = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL haz_stall0 got=%b exp=0", in_ready);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL haz_stall1 got=%b exp=0", in_ready);
        end
        @(posedge clk);
        #1;
        wb_en = 1'b1;
        wb_addr = 4'd1;
        wb_data = 16'h0005;
        model[1] = 16'h0005;
        exp_q.push_back(mk(4'b0010, 16'h0005, 16'h0005, 4'd3));
        @(negedge clk);
        tests++;
`ifdef DECODE_BYPASS_EN
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL haz_wb_cycle got=%b exp=1", in_ready);
        end
`else
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL haz_wb_cycle got=%b exp=0", in_ready);
        end
`endif
        @(posedge clk);
        #1;
        wb_en = 1'b0;
`ifndef DECODE_BYPASS_EN
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL haz_after_wb got=%b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
`endif
        in_valid = 1'b0;
        drain();
        wb(4'd3, 16'h000A);
    endtask

    task automatic test_stall();
        int s;
        out_ready = 1'b1;
        exp_q.push_back(mk(4'b0011, model[1], model[2], 4'd4));
        send(16'h3412, s);
        out_ready = 1'b0;
        instr = 16'h1712;
        in_valid = 1'b1;
        exp_q.push_back(mk(4'b0010, 16'h0, 16'h0012, 4'd7));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if ({out_valid, alu_opcode, alu_a, alu_b, dest, in_ready} !==
                {1'b1, 4'b0011, 16'h0005, 16'hFFFF, 4'd4, 1'b0}) begin
                fails++;
                $display("FAIL hold_c%0d got=%b/%h/%h/%h/%h/%b", c,
                    out_valid, alu_opcode, alu_a, alu_b, dest, in_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL hold_release got=%b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, dest} !== {1'b1, 4'd7}) begin
            fails++;
            $display("FAIL hold_next got=%b/%h exp=1/7", out_valid, dest);
        end
        @(posedge clk);
        #1;
        drain();
        wb(4'd4, 16'h0006);
        wb(4'd7, 16'h0012);
    endtask

    task automatic test_illegal();
        int s;
        send(16'hF123, s);
        @(negedge clk);
        tests++;
        if ({illegal, out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL ill_pulse got=%b/%b exp=1/0", illegal, out_valid);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (illegal !== 1'b0) begin
            fails++; $display("FAIL ill_one_cycle got=%b exp=0", illegal);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(mk(4'b0010, model[1], model[1], 4'd9));
        send(16'h2911, s);
        tests++;
        if (s != 0) begin
            fails++; $display("FAIL ill_no_pend got=%0d exp=0", s);
        end
        drain();
        wb(4'd9, 16'h0009);
        send(16'h0000, s);
        @(negedge clk);
        tests++;
        if ({out_valid, illegal} !== 2'b00) begin
            fails++;
            $display("FAIL nop got=%b/%b exp=0/0", out_valid, illegal);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_r0();
        int s;
        wb(4'd0, 16'hBEEF);
        exp_q.push_back(mk(4'b0010, 16'h0, 16'h0, 4'd5));
        send(16'h2500, s);
        exp_q.push_back(mk(4'b0010, 16'h0, 16'h0007, 4'd0));
        send(16'h1007, s);
        exp_q.push_back(mk(4'b0010, 16'h0, 16'h0, 4'd10));
        send(16'h2A00, s);
        tests++;
        if (s != 0) begin
            fails++; $display("FAIL r0_no_pend got=%0d exp=0", s);
        end
        drain();
        wb(4'd5, 16'h0);
        wb(4'd10, 16'h0);
    endtask

    task automatic test_reset_mid();
        int s;
        out_ready = 1'b0;
        send(16'h1C03, s);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL mid_held got=%b exp=1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL mid_drop got=%b exp=0", out_valid);
        end
        for (int i = 0; i < 16; i++) model[i] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL mid_after got=%b exp=0", out_valid);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(mk(4'b0010, 16'h0, 16'h0, 4'd13));
        send(16'h2D12, s);
        tests++;
        if (s != 0) begin
            fails++; $display("FAIL mid_pend_clear got=%0d exp=0", s);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_li_back_to_back();
        test_hazard();
        test_stall();
        test_illegal();
        test_r0();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
